// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame transmitter.
//   tx_state_t  : frame FSM states
//   *_LEVEL     : line levels for idle, start and stop bits
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam bit IDLE_LEVEL  = 1'b1;
    localparam bit START_LEVEL = 1'b0;
    localparam bit STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts enabled clocks and flags the last one of each
// serial bit period.
//   clk, reset(sync, active-low), en(freeze when 0), clear(hold counter at 0)
//   tick : high on the last enabled cycle of a bit period
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_r;

    assign tick = en & ~clear & (cnt_r == LAST_TICK);

    // Tick counter: wraps at every bit boundary, parked at 0 while cleared.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (en) begin
            if (clear || tick) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter.
// Frame: start bit, WIDTH data bits LSB first, optional parity, stop bit;
// each level held CLKS_PER_BIT enabled clocks.
//   clk, reset(sync, active-low), en(global freeze when 0)
//   valid/data/ready : word handshake, data latched on valid & ready
//   tx   : registered serial line, idles high
//   busy : registered, high outside IDLE
//   done : registered one-cycle pulse in the first IDLE cycle after a frame
module serial_tx
    import serial_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             valid,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    // Parity bit transmitted for a latched word.
    function automatic logic frame_parity(input logic [WIDTH-1:0] w);
        return (PARITY_ODD != 0) ? ~(^w) : (^w);
    endfunction

    tx_state_t        state_r, state_s;
    logic [WIDTH-1:0] shreg_r, shreg_s, shifted_s;
    logic [BW-1:0]    bitcnt_r, bitcnt_s;
    logic             parity_r, parity_s;
    logic             tx_r, tx_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             tick_s;
    logic             ready_s;
    logic             clear_s;

    assign ready_s   = (state_r == IDLE) & en & reset;
    assign clear_s   = (state_r == IDLE);
    assign shifted_s = shreg_r >> 1;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .clear(clear_s),
        .tick (tick_s)
    );

    // Next-state logic; tx_s is the level the line carries in the next state.
    always_comb begin
        state_s  = state_r;
        shreg_s  = shreg_r;
        bitcnt_s = bitcnt_r;
        parity_s = parity_r;
        tx_s     = tx_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        if (en) begin
            case (state_r)
                IDLE: begin
                    if (valid && ready_s) begin
                        shreg_s  = data;
                        parity_s = frame_parity(data);
                        state_s  = START;
                        tx_s     = START_LEVEL;
                        busy_s   = 1'b1;
                    end else begin
                        tx_s   = IDLE_LEVEL;
                        busy_s = 1'b0;
                    end
                end
                START: begin
                    if (tick_s) begin
                        state_s = DATA;
                        tx_s    = shreg_r[0];
                    end else begin
                        tx_s = START_LEVEL;
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        if (bitcnt_r == LAST_BIT) begin
                            bitcnt_s = '0;
                            if (PARITY_EN != 0) begin
                                state_s = PARITY;
                                tx_s    = parity_r;
                            end else begin
                                state_s = STOP;
                                tx_s    = STOP_LEVEL;
                            end
                        end else begin
                            bitcnt_s = bitcnt_r + BW'(1);
                            shreg_s  = shifted_s;
                            tx_s     = shifted_s[0];
                        end
                    end else begin
                        tx_s = shreg_r[0];
                    end
                end
                PARITY: begin
                    if (tick_s) begin
                        state_s = STOP;
                        tx_s    = STOP_LEVEL;
                    end else begin
                        tx_s = parity_r;
                    end
                end
                STOP: begin
                    if (tick_s) begin
                        state_s = IDLE;
                        tx_s    = IDLE_LEVEL;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        tx_s = STOP_LEVEL;
                    end
                end
                default: begin
                    state_s  = IDLE;
                    bitcnt_s = '0;
                    tx_s     = IDLE_LEVEL;
                    busy_s   = 1'b0;
                end
            endcase
        end else begin
            done_s = 1'b0;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= IDLE;
            shreg_r  <= '0;
            bitcnt_r <= '0;
            parity_r <= 1'b0;
            tx_r     <= IDLE_LEVEL;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            shreg_r  <= shreg_s;
            bitcnt_r <= bitcnt_s;
            parity_r <= parity_s;
            tx_r     <= tx_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign ready = ready_s;
    assign tx    = tx_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx. Three instances cover the default
// configuration, odd parity, and no-parity with one clock per bit.
module tb_serial_tx;

    logic       clk;
    logic       reset_v [3];
    logic       en_v    [3];
    logic       valid_v [3];
    logic [7:0] data_v  [3];
    logic       ready_v [3];
    logic       tx_v    [3];
    logic       busy_v  [3];
    logic       done_v  [3];

    int n_chk  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        serial_tx #(
            .WIDTH       (8),
            .CLKS_PER_BIT((g == 2) ? 1 : 4),
            .PARITY_EN   ((g == 2) ? 0 : 1),
            .PARITY_ODD  ((g == 1) ? 1 : 0)
        ) u_dut (
            .clk  (clk),
            .reset(reset_v[g]),
            .en   (en_v[g]),
            .valid(valid_v[g]),
            .data (data_v[g]),
            .ready(ready_v[g]),
            .tx   (tx_v[g]),
            .busy (busy_v[g]),
            .done (done_v[g])
        );
    end

    function automatic int cpb(input int d);
        return (d == 2) ? 1 : 4;
    endfunction

    function automatic int pen(input int d);
        return (d == 2) ? 0 : 1;
    endfunction

    function automatic int podd(input int d);
        return (d == 1) ? 1 : 0;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Sends one word on instance d and checks every cycle of the frame
    // against the expected bit list. par<0 means parity comes from the
    // model (count of ones). Entry/exit alignment: just after a rising
    // edge, except a chained call, which is entered at the falling edge of
    // the previous done cycle.
    task automatic run_frame(input int d, input logic [7:0] w, input int par,
                             input int drop_at, input int drop_len, input int lat,
                             input bit chained, input bit hold, input logic [7:0] nxt,
                             input int rst_at);
        int   c;
        int   nb;
        int   e;
        int   seen;
        bit   fin;
        logic bits [12];
        c  = cpb(d);
        nb = 2 + 8 + pen(d);
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = w[i];
        if (pen(d) != 0) begin
            if (par >= 0) bits[9] = (par != 0);
            else          bits[9] = ((($countones(w) % 2) ^ podd(d)) != 0);
        end
        bits[nb-1] = 1'b1;

        if (!chained) begin
            valid_v[d] = 1'b1;
            data_v[d]  = w;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (ready_v[d]) break;
            end
        end
        chk("ready_at_accept", int'(ready_v[d]), 1);
        @(posedge clk);
        #1;
        if (!hold) begin
            valid_v[d] = 1'b0;
            data_v[d]  = ~w;
        end

        e   = 0;
        fin = 1'b0;
        for (int n = 0; n < 400 && !fin; n++) begin
            en_v[d] = !(n >= drop_at && n < drop_at + drop_len);
            if (n == rst_at) begin
                reset_v[d] = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("abort_tx", int'(tx_v[d]), 1);
                chk("abort_busy", int'(busy_v[d]), 0);
                chk("abort_done", int'(done_v[d]), 0);
                chk("abort_ready", int'(ready_v[d]), 0);
                reset_v[d] = 1'b1;
                seen = 0;
                for (int i = 0; i < 60; i++) begin
                    @(negedge clk);
                    if (done_v[d] || !tx_v[d]) seen++;
                end
                chk("no_done_after_abort", seen, 0);
                @(posedge clk);
                #1;
                fin = 1'b1;
            end else if (e == nb * c) begin
                if (hold) data_v[d] = nxt;
                @(negedge clk);
                chk("done_pulse", int'(done_v[d]), 1);
                chk("done_busy", int'(busy_v[d]), 0);
                chk("done_tx", int'(tx_v[d]), 1);
                chk("done_ready", int'(ready_v[d]), 1);
                chk("latency", n, lat);
                if (!hold) begin
                    @(posedge clk);
                    #1;
                    @(negedge clk);
                    chk("done_single", int'(done_v[d]), 0);
                    @(posedge clk);
                    #1;
                end
                fin = 1'b1;
            end else begin
                @(negedge clk);
                chk("tx_bit", int'(tx_v[d]), int'(bits[e / c]));
                chk("frame_busy", int'(busy_v[d]), 1);
                chk("frame_done", int'(done_v[d]), 0);
                @(posedge clk);
                #1;
                if (en_v[d]) e++;
            end
        end
        en_v[d] = 1'b1;
        if (!fin) begin
            n_chk++;
            n_fail++;
            $display("FAIL frame_timeout: got no done expected done within 400 cycles");
        end
    endtask

    typedef struct {
        int         d;
        logic [7:0] w;
        int         par;
        int         drop_at;
        int         drop_len;
        int         lat;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int d;
        int nb;
        int da;
        int dl;
        logic [7:0] w;

        vecs[0] = '{0, 8'hA5, 0, -1, 0, 44};
        vecs[1] = '{0, 8'hA5, 0, 17, 6, 50};
        vecs[2] = '{1, 8'hA5, 1, -1, 0, 44};
        vecs[3] = '{2, 8'h0F, 0, -1, 0, 10};
        vecs[4] = '{0, 8'h6E, 1, -1, 0, 44};

        for (int i = 0; i < 3; i++) begin
            reset_v[i] = 1'b0;
            en_v[i]    = 1'b1;
            valid_v[i] = 1'b0;
            data_v[i]  = 8'h00;
        end

        // Reset held for two cycles.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("reset_tx", int'(tx_v[0]), 1);
            chk("reset_busy", int'(busy_v[0]), 0);
            chk("reset_done", int'(done_v[0]), 0);
            chk("reset_ready", int'(ready_v[0]), 0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) reset_v[i] = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", int'(ready_v[0]), 1);
        chk("idle_tx", int'(tx_v[0]), 1);
        @(posedge clk);
        #1;

        // Table-driven frames.
        foreach (vecs[i]) begin
            run_frame(vecs[i].d, vecs[i].w, vecs[i].par, vecs[i].drop_at,
                      vecs[i].drop_len, vecs[i].lat, 1'b0, 1'b0, 8'h00, -1);
        end

        // Back-to-back: FF held, 00 presented on the done cycle.
        run_frame(0, 8'hFF, 0, -1, 0, 44, 1'b0, 1'b1, 8'h00, -1);
        run_frame(0, 8'h00, 0, -1, 0, 44, 1'b1, 1'b0, 8'h00, -1);
        run_frame(1, 8'hFF, 1, -1, 0, 44, 1'b0, 1'b1, 8'h00, -1);
        run_frame(1, 8'h00, 1, -1, 0, 44, 1'b1, 1'b0, 8'h00, -1);

        // Reset during data bit 2, then a clean frame.
        run_frame(0, 8'h3C, 0, -1, 0, 44, 1'b0, 1'b0, 8'h00, 13);
        run_frame(0, 8'h55, 0, -1, 0, 44, 1'b0, 1'b0, 8'h00, -1);

        // Randomized frames with random enable drops.
        for (int i = 0; i < 20; i++) begin
            d  = int'($urandom_range(0, 2));
            w  = 8'($urandom);
            nb = (2 + 8 + pen(d)) * cpb(d);
            if ($urandom_range(0, 1) == 0) begin
                da = -1;
                dl = 0;
            end else begin
                da = int'($urandom_range(0, nb - 1));
                dl = int'($urandom_range(1, 5));
            end
            run_frame(d, w, -1, da, dl, nb + dl, 1'b0, 1'b0, 8'h00, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
